// File: rtl/adc_capture_ctrl_if.sv
// Bundles the ADC sample stream and the sample-memory write port.
// Latency: none, wires only.
// Backpressure: wr_ready from the memory side stalls the write port; the sample stream has none.
//
// Signals:
//   sample_valid, adc_x, adc_y : sample stream, ADC front-end -> capture controller
//   wr_valid, wr_addr, wr_data : write request, capture controller -> sample memory
//   wr_ready                   : write accept, sample memory -> capture controller
// Modports:
//   master : capture controller view (consumes samples, issues writes)
//   slave  : environment view (produces samples, accepts writes)
interface adc_capture_ctrl_if #(
    parameter int DATA_BITS = 10,
    parameter int ADDR_BITS = 10
);
    logic                   sample_valid;
    logic [DATA_BITS-1:0]   adc_x;
    logic [DATA_BITS-1:0]   adc_y;

    logic                   wr_valid;
    logic                   wr_ready;
    logic [ADDR_BITS-1:0]   wr_addr;
    logic [2*DATA_BITS-1:0] wr_data;

    modport master (
        input  sample_valid,
        input  adc_x,
        input  adc_y,
        output wr_valid,
        input  wr_ready,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output sample_valid,
        output adc_x,
        output adc_y,
        input  wr_valid,
        output wr_ready,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/adc_capture_ctrl.sv
// Arms on command, waits for an X-level trigger (or the first sample), then writes N {x,y} samples to memory.
// Latency: a sample accepted at cycle t is presented on the write port at cycle t+1.
// Backpressure: one-entry holding register; a sample arriving while it is full and not draining is dropped and flags overrun.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, abort       : one-cycle control pulses (abort wins over everything)
//   trig_en            : 1 = wait for rising crossing of trig_level by X, 0 = trigger on first sample
//   trig_level         : unsigned X trigger level
//   capture_len        : number of samples to capture minus one, latched at start
//   decim              : (only with ADC_CAPTURE_DECIM_EN) keep every (decim+1)-th sample, latched at start
//   bus                : sample stream in, memory write port out
//   busy, done         : status decoded from the state register
//   overrun            : sticky, a capture sample was dropped for lack of room
//
// Build option: define ADC_CAPTURE_DECIM_EN to add the decim input and sample decimation.
module adc_capture_ctrl #(
    parameter int DATA_BITS = 10,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 trig_en,
    input  logic [DATA_BITS-1:0] trig_level,
    input  logic [ADDR_BITS-1:0] capture_len,
`ifdef ADC_CAPTURE_DECIM_EN
    input  logic [7:0]           decim,
`endif
    adc_capture_ctrl_if.master   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Capture bookkeeping. idx_q is one bit wider than an address so a
    // full-depth capture (2^ADDR_BITS samples) can count past the last
    // address without wrapping back to zero.
    logic [ADDR_BITS-1:0]   len_q;
    logic [ADDR_BITS:0]     idx_q;
    logic                   prev_vld_q;
    logic [DATA_BITS-1:0]   prev_x_q;
    logic                   overrun_q;

    // Single-entry holding register feeding the write port.
    logic                   hold_vld_q;
    logic [ADDR_BITS-1:0]   hold_addr_q;
    logic [2*DATA_BITS-1:0] hold_dat_q;

    // Decoded control for the datapath.
    logic arm;        // start honoured this cycle
    logic load_hold;  // a sample enters the holding register
    logic drop;       // an eligible sample is lost to backpressure
    logic drain;      // write handshake this cycle
    logic more;       // fewer than capture_len+1 samples loaded so far
    logic crossing;   // rising crossing of trig_level by X
    logic eligible;   // sample survives decimation

    assign drain    = hold_vld_q & bus.wr_ready;
    assign more     = (idx_q <= {1'b0, len_q});
    // Needs a recorded previous sample, so the first sample after
    // arming can never produce a crossing.
    assign crossing = prev_vld_q
                    && (prev_x_q < trig_level)
                    && (bus.adc_x >= trig_level);

`ifdef ADC_CAPTURE_DECIM_EN
    logic [7:0] decim_q;
    logic [7:0] dec_cnt_q;

    // dec_cnt_q counts valid samples since the last eligible one; the
    // triggering sample resets it to zero, so with decim=N the samples
    // kept are trigger, trigger+N+1, ...
    assign eligible = (dec_cnt_q == decim_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decim_q   <= '0;
            dec_cnt_q <= '0;
        end else begin
            if (arm) begin
                decim_q <= decim;
            end
            if ((state_q == ST_ARMED) && load_hold) begin
                dec_cnt_q <= '0;
            end else if ((state_q == ST_CAPTURE) && !abort
                         && bus.sample_valid && more) begin
                dec_cnt_q <= eligible ? 8'd0 : (dec_cnt_q + 8'd1);
            end
        end
    end
`else
    assign eligible = 1'b1;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        arm       = 1'b0;
        load_hold = 1'b0;
        drop      = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        arm     = 1'b1;
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // The holding register is always empty here, so the
                    // triggering sample is loaded unconditionally as index 0.
                    if (bus.sample_valid && (!trig_en || crossing)) begin
                        load_hold = 1'b1;
                        state_d   = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // Once all samples are loaded, later ones are simply
                    // ignored and never count as overrun.
                    if (bus.sample_valid && eligible && more) begin
                        if (!hold_vld_q || drain) begin
                            load_hold = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                    if (drain && !more) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            idx_q       <= '0;
            prev_vld_q  <= 1'b0;
            prev_x_q    <= '0;
            overrun_q   <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_addr_q <= '0;
            hold_dat_q  <= '0;
        end else begin
            if (arm) begin
                len_q      <= capture_len;
                idx_q      <= '0;
                overrun_q  <= 1'b0;
                prev_vld_q <= 1'b0;
            end

            if ((state_q == ST_ARMED) && bus.sample_valid) begin
                prev_x_q   <= bus.adc_x;
                prev_vld_q <= 1'b1;
            end

            if (drop) begin
                overrun_q <= 1'b1;
            end

            // Abort discards a pending write without a handshake. The
            // index only advances on a successful load, which keeps the
            // addresses contiguous across dropped samples.
            if (abort) begin
                hold_vld_q <= 1'b0;
            end else if (load_hold) begin
                hold_vld_q  <= 1'b1;
                hold_addr_q <= idx_q[ADDR_BITS-1:0];
                hold_dat_q  <= {bus.adc_x, bus.adc_y};
                idx_q       <= idx_q + 1'b1;
            end else if (drain) begin
                hold_vld_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.wr_valid = hold_vld_q;
    assign bus.wr_addr  = hold_addr_q;
    assign bus.wr_data  = hold_dat_q;

    assign busy    = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign done    = (state_q == ST_DONE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: hand-computed capture contents and status.
// Inputs change 1 ns after each rising edge; writes are recorded on the falling edge.
// All comparisons go through check_eq.
`timescale 1ns/1ps
module tb_adc_capture_ctrl;
    localparam int DATA_BITS = 10;
    localparam int ADDR_BITS = 10;
    localparam logic [DATA_BITS-1:0] Y_MASK = 10'h155;

    typedef struct packed {
        logic [ADDR_BITS-1:0]   addr;
        logic [2*DATA_BITS-1:0] dat;
    } wr_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic                 trig_en = 1'b0;
    logic [DATA_BITS-1:0] trig_level = '0;
    logic [ADDR_BITS-1:0] capture_len = '0;
`ifdef ADC_CAPTURE_DECIM_EN
    logic [7:0]           decim = 8'd0;
`endif
    logic                 busy;
    logic                 done;
    logic                 overrun;

    adc_capture_ctrl_if #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) bus ();

    adc_capture_ctrl #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .trig_en     (trig_en),
        .trig_level  (trig_level),
        .capture_len (capture_len),
`ifdef ADC_CAPTURE_DECIM_EN
        .decim       (decim),
`endif
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int                   n_chk = 0;
    int                   n_fail = 0;
    logic                 ramp_on = 1'b0;
    logic [DATA_BITS-1:0] ramp_step = '0;
    wr_t                  cap_q[$];
    int                   exp_x[$];

    always @(negedge clk) begin
        if (rst_n && bus.wr_valid && bus.wr_ready) begin
            cap_q.push_back({bus.wr_addr, bus.wr_data});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_x(input logic [DATA_BITS-1:0] v);
        bus.adc_x = v;
        bus.adc_y = v ^ Y_MASK;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (ramp_on) set_x(bus.adc_x + ramp_step);
    endtask

    // Presents start with the first sample x0; returns one cycle later.
    task automatic arm(input logic [ADDR_BITS-1:0] len, input logic ten,
                       input logic [DATA_BITS-1:0] x0, input logic [DATA_BITS-1:0] step);
        cap_q.delete();
        exp_x.delete();
        capture_len      = len;
        trig_en          = ten;
        ramp_step        = step;
        ramp_on          = 1'b1;
        bus.sample_valid = 1'b1;
        set_x(x0);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            cyc();
            n++;
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic check_capture(input string tag);
        logic [DATA_BITS-1:0] xv;
        check_eq({tag, "_count"}, 32'(cap_q.size()), 32'(exp_x.size()));
        for (int i = 0; i < exp_x.size() && i < cap_q.size(); i++) begin
            xv = DATA_BITS'(exp_x[i]);
            check_eq($sformatf("%s_addr%0d", tag, i), 32'(cap_q[i].addr), 32'(i));
            check_eq($sformatf("%s_data%0d", tag, i), 32'(cap_q[i].dat), 32'({xv, xv ^ Y_MASK}));
        end
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.wr_ready     = 1'b1;
        set_x('0);

        // Reset state
        #12;
        check_eq("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        check_eq("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
        check_eq("rst_wr_data",  32'(bus.wr_data),  32'd0);
        check_eq("rst_busy",     32'(busy),         32'd0);
        check_eq("rst_done",     32'(done),         32'd0);
        check_eq("rst_overrun",  32'(overrun),      32'd0);
        #10 rst_n = 1'b1;
        cyc();

        // Immediate trigger: first sample after arming (x=1) is address 0
        arm(10'd3, 1'b0, 10'd0, 10'd1);
        wait_done("t1", 20);
        for (int i = 0; i < 4; i++) exp_x.push_back(i + 1);
        check_capture("t1");
        check_eq("t1_busy",     32'(busy),         32'd0);
        check_eq("t1_overrun",  32'(overrun),      32'd0);
        check_eq("t1_wr_valid", 32'(bus.wr_valid), 32'd0);

        // Level trigger from DONE: ramp 0x1F0 step 8 crosses 0x200 exactly
        trig_level = 10'h200;
        arm(10'd7, 1'b1, 10'h1F0, 10'd8);
        check_eq("t2_rearm_busy", 32'(busy), 32'd1);
        check_eq("t2_rearm_done", 32'(done), 32'd0);
        wait_done("t2", 40);
        for (int i = 0; i < 8; i++) exp_x.push_back(32'h200 + 8 * i);
        check_capture("t2");

        // First sample after arming sits at the level: must not trigger
        arm(10'd7, 1'b1, 10'h200, 10'd0);
        repeat (6) cyc();
        check_eq("t3_busy",     32'(busy),          32'd1);
        check_eq("t3_wr_valid", 32'(bus.wr_valid),  32'd0);
        check_eq("t3_writes",   32'(cap_q.size()),  32'd0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check_eq("t3_abort_busy", 32'(busy), 32'd0);
        check_eq("t3_abort_done", 32'(done), 32'd0);

        // Abort while a write is stalled
        arm(10'd7, 1'b0, 10'd0, 10'd1);
        cyc();
        bus.wr_ready = 1'b0;
        cyc();
        check_eq("t4_stall_valid",   32'(bus.wr_valid), 32'd1);
        check_eq("t4_stall_overrun", 32'(overrun),      32'd1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check_eq("t4_abort_valid",   32'(bus.wr_valid), 32'd0);
        check_eq("t4_abort_busy",    32'(busy),         32'd0);
        check_eq("t4_abort_overrun", 32'(overrun),      32'd1);
        bus.wr_ready = 1'b1;
        repeat (4) cyc();
        check_eq("t4_writes",   32'(cap_q.size()),  32'd0);
        check_eq("t4_wr_valid", 32'(bus.wr_valid),  32'd0);

        // Re-arm clears overrun; start during capture is ignored
        arm(10'd3, 1'b0, 10'd0, 10'd1);
        check_eq("t5_overrun_clr", 32'(overrun), 32'd0);
        check_eq("t5_busy",        32'(busy),    32'd1);
        cyc();
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done("t5", 20);
        for (int i = 0; i < 4; i++) exp_x.push_back(i + 1);
        check_capture("t5");
        check_eq("t5_overrun", 32'(overrun), 32'd0);

        // Three stalled cycles: samples 3,4,5 dropped, held word stable
        arm(10'd7, 1'b0, 10'd0, 10'd1);
        cyc();
        cyc();
        bus.wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check_eq($sformatf("t6_hold_valid%0d", k), 32'(bus.wr_valid), 32'd1);
            check_eq($sformatf("t6_hold_addr%0d", k),  32'(bus.wr_addr),  32'd1);
            check_eq($sformatf("t6_hold_data%0d", k),  32'(bus.wr_data),
                     32'({10'd2, 10'd2 ^ Y_MASK}));
        end
        bus.wr_ready = 1'b1;
        wait_done("t6", 30);
        exp_x = '{1, 2, 6, 7, 8, 9, 10, 11};
        check_capture("t6");
        check_eq("t6_overrun", 32'(overrun), 32'd1);

        // Full depth: 1024 samples, addresses 0..1023 without wrap
        arm(10'h3FF, 1'b0, 10'd0, 10'd1);
        wait_done("t7", 1100);
        for (int i = 0; i < 1024; i++) exp_x.push_back((i + 1) & 32'h3FF);
        check_capture("t7");
        check_eq("t7_overrun", 32'(overrun), 32'd0);

`ifdef ADC_CAPTURE_DECIM_EN
        // Decimation by 3: keep trigger sample and every third after it
        decim = 8'd2;
        arm(10'd2, 1'b0, 10'd0, 10'd1);
        decim = 8'd0;
        wait_done("t8", 30);
        exp_x = '{1, 4, 7};
        check_capture("t8");
        check_eq("t8_overrun", 32'(overrun), 32'd0);
`endif

        // Asynchronous reset mid-capture with overrun set
        arm(10'd7, 1'b0, 10'd0, 10'd1);
        cyc();
        cyc();
        cyc();
        bus.wr_ready = 1'b0;
        cyc();
        check_eq("t9_pre_addr",    32'(bus.wr_addr), 32'd2);
        check_eq("t9_pre_overrun", 32'(overrun),     32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t9_wr_valid", 32'(bus.wr_valid), 32'd0);
        check_eq("t9_wr_addr",  32'(bus.wr_addr),  32'd0);
        check_eq("t9_wr_data",  32'(bus.wr_data),  32'd0);
        check_eq("t9_busy",     32'(busy),         32'd0);
        check_eq("t9_done",     32'(done),         32'd0);
        check_eq("t9_overrun",  32'(overrun),      32'd0);
        #3 rst_n = 1'b1;
        bus.wr_ready = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Sequences capture of the X/Y sample stream from the ADC front-end into a sample memory. It arms on command, waits for a trigger (rising crossing of X through a level, or immediate), then writes a programmed number of {x,y} samples to a memory write port over a valid/ready handshake. It sits in the main clock domain between the ADC sampler output and the SRAM/frame-buffer writer, and reports busy/done/overrun to the control logic.

Parameters:
DATA_BITS, 10, width of each ADC channel
ADDR_BITS, 10, sample memory address width; max capture depth 2^ADDR_BITS

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; arm a capture (honoured in IDLE or DONE only)
abort  input  1  one-cycle pulse; return to IDLE from any state
trig_en  input  1  1: wait for level crossing; 0: trigger on first valid sample after arming
trig_level  input  DATA_BITS  X trigger level, unsigned
capture_len  input  ADDR_BITS  samples to capture minus 1; sampled at start
sample_valid  input  1  a new adc_x/adc_y pair is present this cycle
adc_x  input  DATA_BITS  X sample
adc_y  input  DATA_BITS  Y sample
wr_valid  output  1  write request to memory
wr_ready  input  1  memory accepts write when wr_valid & wr_ready
wr_addr  output  ADDR_BITS  write address
wr_data  output  2*DATA_BITS  {x, y}
busy  output  1  high in ARMED or CAPTURE
done  output  1  high in DONE
overrun  output  1  sticky; a capture sample was dropped

Behaviour:
- Reset (rst_n low, async): state IDLE; wr_valid 0, wr_addr 0, wr_data 0, busy 0, done 0, overrun 0; internal counters, prev-sample flag, holding register cleared.
- States: IDLE, ARMED, CAPTURE, DONE. busy = ARMED|CAPTURE; done = DONE (registered from state).
- IDLE/DONE + start -> ARMED: latch capture_len, clear sample count, overrun, done, prev flag. start in ARMED/CAPTURE ignored.
- abort has priority over all other events: any state -> IDLE next cycle; wr_valid drops next cycle with no handshake; overrun retained.
- ARMED: on each sample_valid, record prev_x and set prev flag. Trigger when trig_en=0 and sample_valid; or trig_en=1, sample_valid, prev flag set, prev_x < trig_level, adc_x >= trig_level. First sample after arming never triggers when trig_en=1. Trigger -> CAPTURE; triggering sample is capture sample 0 (address 0).
- CAPTURE: single-entry holding register drives wr_valid/wr_addr/wr_data. A valid sample loads when the register is empty or drains the same cycle (wr_valid & wr_ready); wr_addr = sample index. Sample presented at cycle t -> wr_valid at t+1.
- Holding register full, not draining, new sample_valid: sample dropped, overrun set, index NOT advanced (addresses stay contiguous).
- After capture_len+1 samples loaded, further samples ignored (no overrun); -> DONE when last write handshakes. wr_valid deasserts the cycle after.
- wr_addr/wr_data stable while wr_valid & !wr_ready.
- capture_len = 2^ADDR_BITS-1: full depth; index must not wrap before completion.
- Comparisons unsigned; no arithmetic on sample data.

Optional Feature:
ADC_CAPTURE_DECIM_EN: adds input decim [7:0]. In CAPTURE, only every (decim+1)-th valid sample is eligible; triggering sample always eligible and restarts decimation counter; decim latched at start; decim=0 equals no decimation. Ineligible samples never cause overrun. Without macro: port absent, every valid sample eligible.

Test Plan:
- trig_en=0, capture_len=3, wr_ready=1, sample_valid every cycle x=0..: start -> writes addr 0..3, data x=1..4 (first after arm), done=1, busy=0.
- trig_en=1, level=0x200, X ramp 0x1F0 step 8: capture starts at first x>=0x200 (0x200) at addr 0; capture_len=7 -> 8 writes, contiguous.
- wr_ready=0 for 3 cycles mid-capture, sample_valid every cycle: overrun=1, addresses contiguous, dropped samples absent, held data stable while stalled.
- abort during CAPTURE with wr_valid=1, wr_ready=0: IDLE next cycle, wr_valid=0, no further writes; new start re-arms, clears overrun.
- start during CAPTURE ignored; start in DONE re-arms; async rst_n low mid-capture -> all outputs 0 immediately.
- ADC_CAPTURE_DECIM_EN, decim=2, trig_en=0, capture_len=2, x=0..: writes x=1,4,7 at addr 0,1,2.
